// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_mp_pkg : shared register-file constants and clear-FSM state type  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package reg_file_mp_pkg;

   localparam int          c_DATA_W   = 32;
   localparam int          c_ADDR_W   = 5;
   localparam int          c_SP_IDX   = 29;
   localparam int          c_LINK_IDX = 31;
   localparam logic [31:0] c_SP_RESET = 32'd128;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } rf_state_e;

endpackage : reg_file_mp_pkg
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_mp_if : read/write/link/scoreboard/clear bundle of reg_file_mp    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface reg_file_mp_if
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int ADDR_W = c_ADDR_W
);
   logic [ADDR_W-1:0] rs_addr_i;
   logic [ADDR_W-1:0] rt_addr_i;
   logic [DATA_W-1:0] rs_data_o;
   logic [DATA_W-1:0] rt_data_o;
   logic              wr_en_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              link_en_i;
   logic [DATA_W-1:0] link_data_i;
   logic [DATA_W-1:0] link_o;
   logic              issue_en_i;
   logic [ADDR_W-1:0] issue_addr_i;
   logic              rs_busy_o;
   logic              rt_busy_o;
   logic              clear_i;
   logic              clear_busy_o;
   logic              clear_done_o;

   modport master (
      output rs_addr_i, rt_addr_i, wr_en_i, wr_addr_i, wr_data_i,
             link_en_i, link_data_i, issue_en_i, issue_addr_i, clear_i,
      input  rs_data_o, rt_data_o, link_o, rs_busy_o, rt_busy_o,
             clear_busy_o, clear_done_o
   );

   modport slave (
      input  rs_addr_i, rt_addr_i, wr_en_i, wr_addr_i, wr_data_i,
             link_en_i, link_data_i, issue_en_i, issue_addr_i, clear_i,
      output rs_data_o, rt_data_o, link_o, rs_busy_o, rt_busy_o,
             clear_busy_o, clear_done_o
   );
endinterface : reg_file_mp_if
`default_nettype wire

// File: rtl/reg_file_mp_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_scoreboard : per-register pending-write bits for hazard detection       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rf_scoreboard #(
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_set_en,
   input  logic [ADDR_W-1:0] i_set_addr,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic              i_link_en,
   input  logic [ADDR_W-1:0] i_link_addr,
   input  logic              i_seq_en,
   input  logic [ADDR_W-1:0] i_seq_addr,
   input  logic [ADDR_W-1:0] i_rd_a_addr,
   input  logic [ADDR_W-1:0] i_rd_b_addr,
   output logic              o_busy_a,
   output logic              o_busy_b
);
   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0] r_pend;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;

   function automatic logic [NUM_REGS-1:0] f_onehot(input logic en, input logic [ADDR_W-1:0] a);
      f_onehot = '0;
      if (en) f_onehot[a] = 1'b1;
   endfunction

   always_comb begin
      w_set    = f_onehot(i_set_en, i_set_addr);
      w_set[0] = 1'b0;
      w_clr    = f_onehot(i_wr_en, i_wr_addr) | f_onehot(i_link_en, i_link_addr)
               | f_onehot(i_seq_en, i_seq_addr);
   end

   // Set after clear: an issue landing on a just-written index keeps it pending.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_pend <= '0;
      else       r_pend <= (r_pend & ~w_clr) | w_set;
   end

   assign o_busy_a = r_pend[i_rd_a_addr];
   assign o_busy_b = r_pend[i_rd_b_addr];
endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_mp : 2R + main/link write register file, bypass, scoreboard, clear|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int                DATA_W   = c_DATA_W,
   parameter int                ADDR_W   = c_ADDR_W,
   parameter int                SP_IDX   = c_SP_IDX,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(c_SP_RESET),
   parameter int                LINK_IDX = c_LINK_IDX,
   parameter bit                BYPASS   = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   reg_file_mp_if.slave bus
);
   localparam int                NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_LINK   = ADDR_W'(LINK_IDX);
   localparam logic [ADDR_W-1:0] c_SP     = ADDR_W'(SP_IDX);

   rf_state_e         r_state;
   rf_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_clr_idx;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              w_clearing;
   logic              w_link_we;
   logic              w_main_we;
   logic              w_clear_busy;
   logic              w_clear_done;
   logic [DATA_W-1:0] w_clr_val;

   assign w_clearing = (r_state == CLEAR);
   assign w_link_we  = bus.link_en_i && !w_clearing && (c_LINK != '0);
   // Link port owns LINK_IDX when both ports target it.
   assign w_main_we  = bus.wr_en_i && !w_clearing && (bus.wr_addr_i != '0)
                     && !(w_link_we && (bus.wr_addr_i == c_LINK));
   assign w_clr_val  = (r_clr_idx == c_SP) ? SP_RESET : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end else if (w_clearing) begin
         r_regs[r_clr_idx] <= w_clr_val;
      end else begin
         if (w_main_we) r_regs[bus.wr_addr_i] <= bus.wr_data_i;
         if (w_link_we) r_regs[c_LINK]        <= bus.link_data_i;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;
      assign w_addr = (p == 0) ? bus.rs_addr_i : bus.rt_addr_i;
      always_comb begin
         w_data = r_regs[w_addr];
         if (w_addr == '0)
            w_data = '0;
         else if (BYPASS && w_link_we && (w_addr == c_LINK))
            w_data = bus.link_data_i;
         else if (BYPASS && w_main_we && (w_addr == bus.wr_addr_i))
            w_data = bus.wr_data_i;
      end
   end

   assign bus.rs_data_o = g_rd[0].w_data;
   assign bus.rt_data_o = g_rd[1].w_data;
   assign bus.link_o    = r_regs[c_LINK];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_idx <= w_clearing ? r_clr_idx + 1'b1 : '0;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_clear_busy = 1'b0;
      w_clear_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.clear_i) w_state_nxt = CLEAR;
         end
         CLEAR: begin
            w_clear_busy = 1'b1;
            if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
               w_clear_done = 1'b1;
               w_state_nxt  = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.clear_busy_o = w_clear_busy;
   assign bus.clear_done_o = w_clear_done;

   rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_set_en    (bus.issue_en_i && !w_clearing),
      .i_set_addr  (bus.issue_addr_i),
      .i_wr_en     (w_main_we),
      .i_wr_addr   (bus.wr_addr_i),
      .i_link_en   (w_link_we),
      .i_link_addr (c_LINK),
      .i_seq_en    (w_clearing),
      .i_seq_addr  (r_clr_idx),
      .i_rd_a_addr (bus.rs_addr_i),
      .i_rd_b_addr (bus.rt_addr_i),
      .o_busy_a    (bus.rs_busy_o),
      .o_busy_b    (bus.rt_busy_o)
   );
endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_file_mp : random + directed bench for reg_file_mp (BYPASS=1 and 0)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_reg_file_mp;
   import reg_file_mp_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   reg_file_mp_if bus_b ();
   reg_file_mp_if bus_n ();

   assign bus_n.rs_addr_i    = bus_b.rs_addr_i;
   assign bus_n.rt_addr_i    = bus_b.rt_addr_i;
   assign bus_n.wr_en_i      = bus_b.wr_en_i;
   assign bus_n.wr_addr_i    = bus_b.wr_addr_i;
   assign bus_n.wr_data_i    = bus_b.wr_data_i;
   assign bus_n.link_en_i    = bus_b.link_en_i;
   assign bus_n.link_data_i  = bus_b.link_data_i;
   assign bus_n.issue_en_i   = bus_b.issue_en_i;
   assign bus_n.issue_addr_i = bus_b.issue_addr_i;
   assign bus_n.clear_i      = bus_b.clear_i;

   reg_file_mp #(.BYPASS(1'b1)) u_dut_byp (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_b));
   reg_file_mp #(.BYPASS(1'b0)) u_dut_nob (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_n));

   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_clr_active;
   int          m_clr_cnt;
   int          tests_run    = 0;
   int          tests_failed = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = (i == 29) ? 32'd128 : 32'd0;
         m_pend[i] = 1'b0;
      end
      m_clr_active = 1'b0;
      m_clr_cnt    = 0;
   endfunction

   function automatic logic [31:0] m_read(input int a, input bit byp);
      if (a == 0) return 32'd0;
      if (byp && !m_clr_active) begin
         if (bus_b.link_en_i && a == 31) return bus_b.link_data_i;
         if (bus_b.wr_en_i && a == int'(bus_b.wr_addr_i)) return bus_b.wr_data_i;
      end
      return m_regs[a];
   endfunction

   task automatic check_outputs();
      int rs = int'(bus_b.rs_addr_i);
      int rt = int'(bus_b.rt_addr_i);
      check_val("rs_byp",   bus_b.rs_data_o, m_read(rs, 1'b1));
      check_val("rt_byp",   bus_b.rt_data_o, m_read(rt, 1'b1));
      check_val("rs_nob",   bus_n.rs_data_o, m_read(rs, 1'b0));
      check_val("rt_nob",   bus_n.rt_data_o, m_read(rt, 1'b0));
      check_val("link_byp", bus_b.link_o, m_regs[31]);
      check_val("link_nob", bus_n.link_o, m_regs[31]);
      check_val("rs_busy",  32'(bus_b.rs_busy_o), 32'(m_pend[rs]));
      check_val("rt_busy",  32'(bus_b.rt_busy_o), 32'(m_pend[rt]));
      check_val("rs_busy_n", 32'(bus_n.rs_busy_o), 32'(m_pend[rs]));
      check_val("clr_busy", 32'(bus_b.clear_busy_o), 32'(m_clr_active));
      check_val("clr_done", 32'(bus_b.clear_done_o), 32'(m_clr_active && m_clr_cnt == 31));
      check_val("clr_busy_n", 32'(bus_n.clear_busy_o), 32'(m_clr_active));
   endtask

   function automatic void m_update();
      if (m_clr_active) begin
         m_regs[m_clr_cnt] = (m_clr_cnt == 29) ? 32'd128 : 32'd0;
         m_pend[m_clr_cnt] = 1'b0;
         m_clr_cnt++;
         if (m_clr_cnt == 32) begin
            m_clr_active = 1'b0;
            m_clr_cnt    = 0;
         end
      end else begin
         int  wa   = int'(bus_b.wr_addr_i);
         bit  lnk  = bus_b.link_en_i;
         bit  main = bus_b.wr_en_i && wa != 0 && !(lnk && wa == 31);
         if (main) begin m_regs[wa] = bus_b.wr_data_i;   m_pend[wa] = 1'b0; end
         if (lnk)  begin m_regs[31] = bus_b.link_data_i; m_pend[31] = 1'b0; end
         if (bus_b.issue_en_i && bus_b.issue_addr_i != 5'd0) m_pend[int'(bus_b.issue_addr_i)] = 1'b1;
         if (bus_b.clear_i) begin
            m_clr_active = 1'b1;
            m_clr_cnt    = 0;
         end
      end
   endfunction

   task automatic drive_idle(input logic [4:0] rs, input logic [4:0] rt);
      bus_b.rs_addr_i    = rs;
      bus_b.rt_addr_i    = rt;
      bus_b.wr_en_i      = 1'b0;
      bus_b.wr_addr_i    = 5'd0;
      bus_b.wr_data_i    = 32'd0;
      bus_b.link_en_i    = 1'b0;
      bus_b.link_data_i  = 32'd0;
      bus_b.issue_en_i   = 1'b0;
      bus_b.issue_addr_i = 5'd0;
      bus_b.clear_i      = 1'b0;
   endtask

   task automatic cycle();
      @(negedge clk_i);
      check_outputs();
      @(posedge clk_i);
      #1;
      m_update();
   endtask

   task automatic read_all();
      for (int i = 0; i < 32; i++) begin
         drive_idle(5'(i), 5'(31 - i));
         cycle();
      end
   endtask

   initial begin
      int busy_cnt;
      int done_at;
      int guard;

      rst_i = 1'b1;
      drive_idle(5'd0, 5'd0);
      repeat (2) @(posedge clk_i);
      #1;
      m_reset();
      rst_i = 1'b0;
      read_all();

      // same-cycle bypass on r5
      drive_idle(5'd5, 5'd0);
      bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd5; bus_b.wr_data_i = 32'hDEADBEEF;
      cycle();
      drive_idle(5'd5, 5'd31);
      cycle();

      // main and link collide on r31, then split
      drive_idle(5'd31, 5'd8);
      bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd31; bus_b.wr_data_i = 32'h11;
      bus_b.link_en_i = 1'b1; bus_b.link_data_i = 32'h400;
      cycle();
      drive_idle(5'd31, 5'd8);
      cycle();
      check_val("link_wins", bus_b.link_o, 32'h400);
      bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd8; bus_b.wr_data_i = 32'h22;
      bus_b.link_en_i = 1'b1; bus_b.link_data_i = 32'h404;
      cycle();
      drive_idle(5'd8, 5'd31);
      cycle();

      // scoreboard on r7
      drive_idle(5'd7, 5'd7);
      bus_b.issue_en_i = 1'b1; bus_b.issue_addr_i = 5'd7;
      cycle();
      drive_idle(5'd7, 5'd0);
      cycle();
      bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd7; bus_b.wr_data_i = 32'h7;
      cycle();
      drive_idle(5'd7, 5'd0);
      cycle();
      bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd7; bus_b.wr_data_i = 32'h77;
      bus_b.issue_en_i = 1'b1; bus_b.issue_addr_i = 5'd7;
      cycle();
      drive_idle(5'd7, 5'd0);
      cycle();
      check_val("issue_wr_same", 32'(bus_b.rs_busy_o), 32'd1);

      // soft clear with writes, issues and clear_i ignored while running
      drive_idle(5'd3, 5'd29);
      bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd3; bus_b.wr_data_i = 32'd9;
      cycle();
      drive_idle(5'd3, 5'd29);
      bus_b.clear_i = 1'b1;
      cycle();
      busy_cnt = 0;
      done_at  = -1;
      for (int k = 0; k < 34; k++) begin
         drive_idle(5'd3, 5'd29);
         bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd3; bus_b.wr_data_i = 32'h55;
         bus_b.issue_en_i = 1'b1; bus_b.issue_addr_i = 5'd3;
         bus_b.clear_i = (k < 32);
         if (k >= 32) begin bus_b.wr_en_i = 1'b0; bus_b.issue_en_i = 1'b0; end
         @(negedge clk_i);
         check_outputs();
         if (bus_b.clear_busy_o) busy_cnt++;
         if (bus_b.clear_done_o) done_at = k;
         @(posedge clk_i);
         #1;
         m_update();
      end
      check_val("clr_len", 32'(busy_cnt), 32'd32);
      check_val("clr_done_at", 32'(done_at), 32'd31);
      drive_idle(5'd3, 5'd29);
      cycle();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wa = 5'($urandom_range(0, 31));
         drive_idle(($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
         bus_b.wr_en_i      = ($urandom_range(0, 2) != 0);
         bus_b.wr_addr_i    = wa;
         bus_b.wr_data_i    = $urandom;
         bus_b.link_en_i    = ($urandom_range(0, 3) == 0);
         bus_b.link_data_i  = $urandom;
         bus_b.issue_en_i   = ($urandom_range(0, 1) == 0);
         bus_b.issue_addr_i = 5'($urandom_range(0, 31));
         bus_b.clear_i      = ($urandom_range(0, 99) == 0);
         cycle();
      end

      // reset in the middle of a clear
      guard = 0;
      drive_idle(5'd0, 5'd0);
      while (m_clr_active && guard < 40) begin
         cycle();
         guard++;
      end
      check_val("clr_idle_bound", 32'(m_clr_active), 32'd0);
      for (int i = 1; i < 32; i++) begin
         drive_idle(5'd0, 5'd0);
         bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'(i); bus_b.wr_data_i = 32'hA500 + 32'(i);
         bus_b.issue_en_i = 1'b1; bus_b.issue_addr_i = 5'(32 - i);
         cycle();
      end
      drive_idle(5'd20, 5'd12);
      bus_b.clear_i = 1'b1;
      cycle();
      drive_idle(5'd20, 5'd12);
      for (int k = 0; k < 10; k++) cycle();
      check_val("clr_idx_at_rst", 32'(m_clr_cnt), 32'd10);
      rst_i = 1'b1;
      m_reset();
      @(negedge clk_i);
      check_outputs();
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      read_all();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule : tb_reg_file_mp
`default_nettype wire
